// File: rtl/sprite_line_fetcher.sv
// Sprite line fetcher: walks the sprite slots during hblank, fetches one
// 8-pixel ROM line per covering sprite and commits the full line set at once.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start, next_row     scan request and the scanline it targets
//   slot_sel            slot being queried; slot_* return its fields
//   rom_*               ROM request (read strobe, id, orientation, line)
//   rom_data            combinational ROM line, active-low pixels
//   line_data/valid     committed lines and hit flags, one byte/bit per slot
//   busy, done          scan in progress, single-cycle commit pulse
module sprite_line_fetcher #(
   parameter int NUM_SLOTS  = 4,
   parameter int SCALE_LOG2 = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [9:0]             next_row,
   output logic [2:0]             slot_sel,
   input  logic                   slot_enable,
   input  logic [3:0]             slot_id,
   input  logic [1:0]             slot_orient,
   input  logic [9:0]             slot_y,
   output logic                   rom_read_enable,
   output logic [3:0]             rom_sprite_ID,
   output logic [1:0]             rom_orientation,
   output logic [2:0]             rom_line_index,
   input  logic [7:0]             rom_data,
   output logic [8*NUM_SLOTS-1:0] line_data,
   output logic [NUM_SLOTS-1:0]   line_valid,
   output logic                   busy,
   output logic                   done
);

   localparam logic [10:0] HEIGHT = 11'(8 << SCALE_LOG2);
   localparam logic [2:0]  LAST   = 3'(NUM_SLOTS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SELECT,
      S_FETCH,
      S_DONE
   } state_t;

   state_t                 state_q;
   logic [9:0]             row_q;
   logic [2:0]             cnt_q;
   logic [2:0]             slot_sel_q;
   logic                   hit_q;
   logic                   rom_en_q;
   logic [3:0]             rom_id_q;
   logic [1:0]             rom_or_q;
   logic [2:0]             rom_ln_q;
   logic [8*NUM_SLOTS-1:0] shadow_q;
   logic [NUM_SLOTS-1:0]   svld_q;
   logic [8*NUM_SLOTS-1:0] line_q;
   logic [NUM_SLOTS-1:0]   lvld_q;
   logic                   busy_q;
   logic                   done_q;

   logic [10:0]            diff;
   logic                   hit_c;
   logic [2:0]             line_c;
   logic [8*NUM_SLOTS-1:0] shadow_d;
   logic [NUM_SLOTS-1:0]   svld_d;

   // Negative diff (sprite starts below the row) sets bit 10 and misses.
   assign diff   = {1'b0, row_q} - {1'b0, slot_y};
   assign hit_c  = slot_enable & ~diff[10] & (diff < HEIGHT);
   assign line_c = diff[SCALE_LOG2+2:SCALE_LOG2];

   // Shadow with the current FETCH result merged in; lets the last slot
   // land in the committed set on the same edge that raises done.
   always_comb begin
      shadow_d = shadow_q;
      svld_d   = svld_q;
      for (int k = 0; k < NUM_SLOTS; k++) begin
         if (hit_q && cnt_q == 3'(k)) begin
            shadow_d[8*k +: 8] = rom_data;
            svld_d[k]          = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         row_q      <= '0;
         cnt_q      <= '0;
         slot_sel_q <= '0;
         hit_q      <= 1'b0;
         rom_en_q   <= 1'b0;
         rom_id_q   <= '0;
         rom_or_q   <= '0;
         rom_ln_q   <= '0;
         shadow_q   <= '1;
         svld_q     <= '0;
         line_q     <= '1;
         lvld_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  row_q      <= next_row;
                  cnt_q      <= '0;
                  slot_sel_q <= '0;
                  shadow_q   <= '1;
                  svld_q     <= '0;
                  busy_q     <= 1'b1;
                  state_q    <= S_SELECT;
               end
            end
            S_SELECT: begin
               hit_q    <= hit_c;
               rom_en_q <= hit_c;
               rom_id_q <= hit_c ? slot_id : 4'd0;
               rom_or_q <= hit_c ? slot_orient : 2'd0;
               rom_ln_q <= hit_c ? line_c : 3'd0;
               state_q  <= S_FETCH;
            end
            S_FETCH: begin
               rom_en_q <= 1'b0;
               rom_id_q <= '0;
               rom_or_q <= '0;
               rom_ln_q <= '0;
               hit_q    <= 1'b0;
               shadow_q <= shadow_d;
               svld_q   <= svld_d;
               if (cnt_q == LAST) begin
                  line_q  <= shadow_d;
                  lvld_q  <= svld_d;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  cnt_q      <= cnt_q + 3'd1;
                  slot_sel_q <= cnt_q + 3'd1;
                  state_q    <= S_SELECT;
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign slot_sel        = slot_sel_q;
   assign rom_read_enable = rom_en_q;
   assign rom_sprite_ID   = rom_id_q;
   assign rom_orientation = rom_or_q;
   assign rom_line_index  = rom_ln_q;
   assign line_data       = line_q;
   assign line_valid      = lvld_q;
   assign busy            = busy_q;
   assign done            = done_q;

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Bench for sprite_line_fetcher: directed and randomized scans checked
// against an arithmetic model of sprite coverage and ROM contents.
module tb_sprite_line_fetcher;

   localparam int NS = 4;
   localparam int S  = 3;
   localparam int H  = 8 << S;

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic [9:0]      next_row;
   logic [2:0]      slot_sel;
   logic            slot_enable;
   logic [3:0]      slot_id;
   logic [1:0]      slot_orient;
   logic [9:0]      slot_y;
   logic            rom_read_enable;
   logic [3:0]      rom_sprite_ID;
   logic [1:0]      rom_orientation;
   logic [2:0]      rom_line_index;
   logic [7:0]      rom_data;
   logic [8*NS-1:0] line_data;
   logic [NS-1:0]   line_valid;
   logic            busy;
   logic            done;

   logic       t_en [8];
   logic [3:0] t_id [8];
   logic [1:0] t_or [8];
   logic [9:0] t_y  [8];

   int n_checks = 0;
   int n_err    = 0;
   int rom_reads = 0;
   int rom_bad   = 0;
   int done_cnt  = 0;

   sprite_line_fetcher #(.NUM_SLOTS(NS), .SCALE_LOG2(S)) dut (
      .clk(clk), .reset(reset), .start(start), .next_row(next_row),
      .slot_sel(slot_sel), .slot_enable(slot_enable), .slot_id(slot_id),
      .slot_orient(slot_orient), .slot_y(slot_y),
      .rom_read_enable(rom_read_enable), .rom_sprite_ID(rom_sprite_ID),
      .rom_orientation(rom_orientation), .rom_line_index(rom_line_index),
      .rom_data(rom_data), .line_data(line_data), .line_valid(line_valid),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] rom_fn(logic [3:0] id, logic [1:0] o,
                                         logic [2:0] l);
      return 8'h5A ^ {id, o, 2'b00} ^ {l, l[1:0], l};
   endfunction

   assign slot_enable = t_en[slot_sel];
   assign slot_id     = t_id[slot_sel];
   assign slot_orient = t_or[slot_sel];
   assign slot_y      = t_y[slot_sel];
   assign rom_data    = rom_read_enable ?
      rom_fn(rom_sprite_ID, rom_orientation, rom_line_index) : 8'h00;

   always @(negedge clk) begin
      if (rom_read_enable === 1'b1) rom_reads++;
      else if ({rom_sprite_ID, rom_orientation, rom_line_index} !== 9'd0)
         rom_bad++;
      if (done === 1'b1) done_cnt++;
   end

   task automatic chk(input string tag, input logic [63:0] act,
                      input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Reference: a slot hits when the row lies in [y, y+H) with no wrap.
   task automatic model(output logic [8*NS-1:0] d, output logic [NS-1:0] v,
                        output int hits);
      int r, y, off;
      d = '1;
      v = '0;
      hits = 0;
      r = int'(next_row);
      for (int k = 0; k < NS; k++) begin
         y = int'(t_y[k]);
         off = r - y;
         if (t_en[k] && off >= 0 && off < H) begin
            v[k] = 1'b1;
            d[8*k +: 8] = rom_fn(t_id[k], t_or[k], 3'(off / (H / 8)));
            hits++;
         end
      end
   endtask

   task automatic run_scan(input string tag, input int extra_start);
      logic [8*NS-1:0] ed, pd;
      logic [NS-1:0]   ev, pv;
      int hits, n, d0;
      bit stable;
      model(ed, ev, hits);
      pd = line_data;
      pv = line_valid;
      rom_reads = 0;
      rom_bad = 0;
      d0 = done_cnt;
      stable = 1;
      start = 1'b1;
      cyc();
      start = 1'b0;
      n = 1;
      chk({tag, "_busy"}, busy, 1'b1);
      while (done !== 1'b1 && n < 40) begin
         if (line_data !== pd || line_valid !== pv) stable = 0;
         if (extra_start != 0 && n == extra_start) start = 1'b1;
         cyc();
         start = 1'b0;
         n++;
      end
      chk({tag, "_latency"}, n, 2 * NS + 1);
      chk({tag, "_hold"}, stable, 1);
      chk({tag, "_data"}, line_data, ed);
      chk({tag, "_valid"}, line_valid, ev);
      chk({tag, "_romreads"}, rom_reads, hits);
      chk({tag, "_romidle"}, rom_bad, 0);
      repeat (4) cyc();
      chk({tag, "_donecnt"}, done_cnt - d0, 1);
      chk({tag, "_idle"}, busy, 1'b0);
   endtask

   task automatic clr_table();
      for (int k = 0; k < 8; k++) begin
         t_en[k] = 1'b0;
         t_id[k] = 4'(k);
         t_or[k] = 2'(k);
         t_y[k]  = 10'd0;
      end
   endtask

   initial begin
      int d0;
      clr_table();
      reset = 1'b1;
      start = 1'b0;
      next_row = '0;
      repeat (2) cyc();
      reset = 1'b0;
      rom_reads = 0;
      repeat (5) cyc();
      chk("rst_data", line_data, {(8*NS){1'b1}});
      chk("rst_valid", line_valid, '0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_sel", slot_sel, 3'd0);
      chk("rst_rom", rom_reads, 0);

      t_en[0] = 1'b1; t_id[0] = 4'd0; t_or[0] = 2'd0; t_y[0] = 10'd100;
      next_row = 10'd124;
      run_scan("single", 0);

      clr_table();
      for (int k = 0; k < 4; k++) begin
         t_en[k] = 1'b1;
         t_y[k]  = 10'(40 * k);
      end
      next_row = 10'd47;
      run_scan("four", 0);

      clr_table();
      t_en[2] = 1'b1; t_id[2] = 4'd9; t_or[2] = 2'd3; t_y[2] = 10'd200;
      next_row = 10'd199; run_scan("b199", 0);
      next_row = 10'd200; run_scan("b200", 0);
      next_row = 10'd263; run_scan("b263", 0);
      next_row = 10'd264; run_scan("b264", 0);

      t_en[1] = 1'b1; t_id[1] = 4'd5; t_or[1] = 2'd1; t_y[1] = 10'd1000;
      next_row = 10'd1023; run_scan("top", 0);

      next_row = 10'd230;
      run_scan("dblstart", 3);

      for (int i = 0; i < 30; i++) begin
         next_row = 10'($urandom_range(0, 1023));
         for (int k = 0; k < NS; k++) begin
            t_en[k] = 1'($urandom_range(0, 3) != 0);
            t_id[k] = 4'($urandom);
            t_or[k] = 2'($urandom);
            if ($urandom_range(0, 1) == 0) t_y[k] = 10'($urandom);
            else t_y[k] = next_row - 10'($urandom_range(0, 80));
         end
         run_scan("rand", 0);
      end

      clr_table();
      t_en[0] = 1'b1; t_y[0] = 10'd100;
      t_en[2] = 1'b1; t_y[2] = 10'd90;
      next_row = 10'd124;
      run_scan("prereset", 0);
      d0 = done_cnt;
      start = 1'b1;
      cyc();
      start = 1'b0;
      repeat (5) cyc();
      chk("midfetch_rom", rom_read_enable, 1'b1);
      reset = 1'b1;
      start = 1'b1;
      cyc();
      reset = 1'b0;
      start = 1'b0;
      chk("mid_data", line_data, {(8*NS){1'b1}});
      chk("mid_valid", line_valid, '0);
      chk("mid_busy", busy, 1'b0);
      chk("mid_rom", rom_read_enable, 1'b0);
      repeat (12) cyc();
      chk("mid_nodone", done_cnt - d0, 0);
      chk("mid_stay", busy, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
